centroid_writeback: RTL and testbench

CENTROID_WRITEBACK -- requirements
Module: centroid_writeback

---
 rtl/centroid_writeback_pkg.sv | 25 ++
 rtl/centroid_writeback_fifo.sv | 61 ++++++
 rtl/centroid_writeback.sv | 136 +++++++++++++
 tb/tb_centroid_writeback.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_writeback_pkg.sv
// Shared types for the k-means centroid write-back path: widths, FSM states
// and the buffered beat layout.
package kmeansTypes;

  localparam int FIFO_DEPTH_DEF = 64;
  localparam int DATA_W         = 512;
  localparam int ADDR_W         = 58;
  localparam int CNT_W          = 32;
  localparam int OUTST_W        = 16;
  localparam int TAG_W          = 8;
  localparam int BEAT_W         = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/centroid_writeback_fifo.sv
// Synchronous update-beat buffer. The head entry is read from storage flops,
// so a beat written at one edge becomes visible only after that edge.
module wr_update_fifo
  import kmeansTypes::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = BEAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/centroid_writeback.sv
// Buffers centroid update beats from the k-means core and writes them to a
// fixed cache-line region, one region rewrite per iteration.
module centroid_writeback
  import kmeansTypes::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_operator,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [CNT_W-1:0]    num_iterations,
  input  logic [DATA_W-1:0]   update,
  input  logic                update_valid,
  input  logic                update_last,
  output logic [ADDR_W-1:0]   um_tx_wr_addr,
  output logic [TAG_W-1:0]    um_tx_wr_tag,
  output logic                um_tx_wr_valid,
  output logic [DATA_W-1:0]   um_tx_data,
  input  logic                um_tx_wr_ready,
  input  logic                um_rx_wr_valid,
  input  logic [TAG_W-1:0]    um_rx_wr_tag,
  output logic                um_done,
  output logic                overflow,
  output logic [CNT_W-1:0]    wr_debug_cnt
);

  wb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   dst_q;
  logic [CNT_W-1:0]    niter_q;
  logic [CNT_W-1:0]    iter_cnt_q;
  logic [CNT_W-1:0]    iter_next;
  logic [ADDR_W-1:0]   cl_off_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic [OUTST_W-1:0]  outst_q;
  logic                ovf_q;

  logic                active;
  logic                start_acc;
  logic                push;
  logic                last_seen;
  logic                tx_valid;
  logic                tx_fire;
  logic                fifo_full;
  logic                fifo_empty;
  beat_t               fifo_din;
  beat_t               fifo_dout;
  logic                unused_rx_tag;

  // Completion tags carry no information for this block.
  assign unused_rx_tag = ^um_rx_wr_tag;

  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_acc = (state_q == ST_IDLE) && start_operator;
  assign push      = active && update_valid;
  assign last_seen = push && update_last;
  assign iter_next = iter_cnt_q + CNT_W'(1);
  assign tx_valid  = active && !fifo_empty;
  assign tx_fire   = tx_valid && um_tx_wr_ready;
  assign fifo_din  = '{last: update_last, data: update};

  wr_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BEAT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start_acc),
    .push  (push),
    .din   (fifo_din),
    .pop   (tx_fire),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_operator) state_d = ST_RUN;
      ST_RUN: begin
        if (niter_q == '0)                              state_d = ST_DRAIN;
        else if (last_seen && (iter_next == niter_q))   state_d = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty && (outst_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q      <= '0;
      niter_q    <= '0;
      iter_cnt_q <= '0;
      cl_off_q   <= '0;
      wr_cnt_q   <= '0;
      outst_q    <= '0;
      ovf_q      <= 1'b0;
    end else if (start_acc) begin
      dst_q      <= dst_addr;
      niter_q    <= num_iterations;
      iter_cnt_q <= '0;
      cl_off_q   <= '0;
      wr_cnt_q   <= '0;
      outst_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // Dropped beats still count toward the iteration total.
      if (last_seen) iter_cnt_q <= iter_next;
      if (push && fifo_full && !tx_fire) ovf_q <= 1'b1;
      if (tx_fire) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        cl_off_q <= fifo_dout.last ? '0 : cl_off_q + ADDR_W'(1);
      end
      if (tx_fire && !um_rx_wr_valid)
        outst_q <= outst_q + OUTST_W'(1);
      else if (!tx_fire && um_rx_wr_valid && (outst_q != '0))
        outst_q <= outst_q - OUTST_W'(1);
    end
  end

  assign um_tx_wr_valid = tx_valid;
  assign um_tx_wr_addr  = dst_q + cl_off_q;
  assign um_tx_wr_tag   = wr_cnt_q[TAG_W-1:0];
  assign um_tx_data     = tx_valid ? fifo_dout.data : '0;
  assign um_done        = (state_q == ST_DONE);
  assign overflow       = ovf_q;
  assign wr_debug_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_centroid_writeback.sv
// Randomized bench for centroid_writeback with a queue-based reference model
// and directed scenarios pinning addresses, tags, overflow and reset behaviour.
module tb_centroid_writeback;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_operator;
  logic [57:0]  dst_addr;
  logic [31:0]  num_iterations;
  logic [511:0] update;
  logic         update_valid;
  logic         update_last;
  logic [57:0]  um_tx_wr_addr;
  logic [7:0]   um_tx_wr_tag;
  logic         um_tx_wr_valid;
  logic [511:0] um_tx_data;
  logic         um_tx_wr_ready;
  logic         um_rx_wr_valid;
  logic [7:0]   um_rx_wr_tag;
  logic         um_done;
  logic         overflow;
  logic [31:0]  wr_debug_cnt;

  always #5 clk = ~clk;

  centroid_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_operator (start_operator),
    .dst_addr       (dst_addr),
    .num_iterations (num_iterations),
    .update         (update),
    .update_valid   (update_valid),
    .update_last    (update_last),
    .um_tx_wr_addr  (um_tx_wr_addr),
    .um_tx_wr_tag   (um_tx_wr_tag),
    .um_tx_wr_valid (um_tx_wr_valid),
    .um_tx_data     (um_tx_data),
    .um_tx_wr_ready (um_tx_wr_ready),
    .um_rx_wr_valid (um_rx_wr_valid),
    .um_rx_wr_tag   (um_rx_wr_tag),
    .um_done        (um_done),
    .overflow       (overflow),
    .wr_debug_cnt   (wr_debug_cnt)
  );

  typedef struct {
    logic         last;
    logic [511:0] data;
  } beat_s;

  // Reference model: phase 0 idle, 1 collecting iterations, 2 draining, 3 done.
  beat_s        mq[$];
  int           m_ph;
  logic [57:0]  m_dst;
  logic [57:0]  m_off;
  logic [31:0]  m_num;
  logic [31:0]  m_iters;
  logic [31:0]  m_wr;
  int           m_out;
  bit           m_ovf;

  int n_cmp = 0;
  int n_fail = 0;
  int pend = 0;
  int done_cnt = 0;
  int rdy_pct = 100;
  int rx_pct = 100;
  int spur_pct = 0;
  logic [57:0] log_addr[$];
  logic [7:0]  log_tag[$];

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [511:0] rand_wide();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ph = 0; m_dst = '0; m_off = '0; m_num = '0; m_iters = '0;
    m_wr = '0; m_out = 0; m_ovf = 0;
  endfunction

  function automatic void model_step(bit exp_valid);
    bit    pop;
    bit    was_empty;
    bit    hit_last;
    int    out0;
    beat_s b;
    pop       = exp_valid && um_tx_wr_ready;
    was_empty = (mq.size() == 0);
    out0      = m_out;
    hit_last  = 0;
    if (pop && !um_rx_wr_valid) m_out++;
    else if (!pop && um_rx_wr_valid && m_out > 0) m_out--;
    case (m_ph)
      0: if (start_operator) begin
        m_dst = dst_addr; m_num = num_iterations; m_iters = '0; m_off = '0;
        m_wr = '0; m_out = 0; m_ovf = 0; mq.delete(); m_ph = 1;
      end
      1, 2: begin
        if (pop) begin
          b = mq.pop_front();
          m_off = b.last ? 58'd0 : m_off + 58'd1;
          m_wr++;
        end
        if (update_valid) begin
          if (mq.size() < DEPTH) begin
            b.last = update_last; b.data = update;
            mq.push_back(b);
          end else m_ovf = 1;
          if (update_last) begin
            m_iters++;
            hit_last = (m_iters == m_num);
          end
        end
        if (m_ph == 1 && (m_num == 0 || hit_last)) m_ph = 2;
        else if (m_ph == 2 && was_empty && out0 == 0) m_ph = 3;
      end
      default: m_ph = 0;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    bit ev;
    if (!rst_n) begin
      model_reset();
      pend = 0;
    end else begin
      ev = (m_ph == 1 || m_ph == 2) && mq.size() > 0;
      chk("tx_valid", um_tx_wr_valid, ev);
      chk("um_done", um_done, m_ph == 3);
      chk("overflow", overflow, m_ovf);
      chk("wr_debug_cnt", wr_debug_cnt, m_wr);
      if (ev) begin
        chk("tx_addr", um_tx_wr_addr, m_dst + m_off);
        chk("tx_tag", um_tx_wr_tag, m_wr[7:0]);
        chk("tx_data", um_tx_data, mq[0].data);
      end
      if (um_done) done_cnt++;
      if (um_tx_wr_valid && um_tx_wr_ready) begin
        log_addr.push_back(um_tx_wr_addr);
        log_tag.push_back(um_tx_wr_tag);
        pend++;
      end
      if (um_rx_wr_valid && pend > 0) pend--;
      model_step(ev);
    end
  end

  task automatic step();
    um_tx_wr_ready = ($urandom_range(99) < rdy_pct);
    um_rx_wr_valid = (pend > 0 && $urandom_range(99) < rx_pct) ||
                     (pend == 0 && $urandom_range(99) < spur_pct);
    um_rx_wr_tag   = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) step();
    chk("done_seen", done_cnt != d0, 1'b1);
  endtask

  task automatic send_beats(input int niter, input int bpi, input int gap_pct);
    for (int it = 0; it < niter; it++) begin
      for (int b = 0; b < bpi; b++) begin
        while ($urandom_range(99) < gap_pct) step();
        update_valid = 1'b1;
        update       = rand_wide();
        update_last  = (b == bpi - 1);
        step();
      end
    end
    update_valid = 1'b0;
    update_last  = 1'b0;
  endtask

  task automatic start_op(input logic [57:0] dst, input int niter);
    start_operator = 1'b1;
    dst_addr       = dst;
    num_iterations = 32'(niter);
    step();
    start_operator = 1'b0;
  endtask

  task automatic run_op(input logic [57:0] dst, input int niter, input int bpi, input int gap_pct);
    int d0;
    d0 = done_cnt;
    start_op(dst, niter);
    send_beats(niter, bpi, gap_pct);
    wait_done(d0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, um_tx_wr_valid, 1'b0);
    chk({tag, "_done"}, um_done, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_cnt"}, wr_debug_cnt, 32'd0);
    chk({tag, "_addr"}, um_tx_wr_addr, 58'd0);
    chk({tag, "_tag"}, um_tx_wr_tag, 8'd0);
    chk({tag, "_data"}, um_tx_data, 512'd0);
  endtask

  initial begin : stim
    logic [57:0]  dst;
    logic [511:0] first_data;
    int           d0;
    int           offs[6];
    offs = '{0, 1, 0, 1, 0, 1};

    rst_n = 1'b0; start_operator = 1'b0; dst_addr = '0; num_iterations = '0;
    update = '0; update_valid = 1'b0; update_last = 1'b0;
    um_tx_wr_ready = 1'b0; um_rx_wr_valid = 1'b0; um_rx_wr_tag = '0;
    #1;
    check_zero_outputs("reset");
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // One iteration of four beats, always ready, one completion per write.
    rdy_pct = 100; rx_pct = 100; spur_pct = 0;
    dst = 58'h1_2345_6789_ABC0;
    log_addr.delete(); log_tag.delete();
    d0 = done_cnt;
    run_op(dst, 1, 4, 0);
    repeat (4) step();
    chk("t1_writes", log_addr.size(), 4);
    chk("t1_done_once", done_cnt - d0, 1);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("t1_addr", log_addr[i], dst + 58'(i));
      chk("t1_tag", log_tag[i], 8'(i));
    end

    // Three iterations of two beats rewrite the same two lines.
    dst = 58'h0_0000_0000_1000;
    log_addr.delete(); log_tag.delete();
    run_op(dst, 3, 2, 20);
    chk("t2_writes", log_addr.size(), 6);
    chk("t2_wr_cnt", wr_debug_cnt, 32'd6);
    for (int i = 0; i < 6 && i < log_addr.size(); i++)
      chk("t2_addr", log_addr[i], dst + 58'(offs[i]));

    // Stalled channel: six beats into a four-entry buffer.
    dst = 58'h3_FFFF_0000_0040;
    log_addr.delete(); log_tag.delete();
    rdy_pct = 0;
    d0 = done_cnt;
    start_op(dst, 1);
    update_valid = 1'b1; update_last = 1'b0;
    update = rand_wide(); first_data = update;
    step();
    for (int b = 1; b < 6; b++) begin
      update = rand_wide(); update_last = (b == 5);
      step();
    end
    update_valid = 1'b0; update_last = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        chk("t3_stall_valid", um_tx_wr_valid, 1'b1);
        chk("t3_stall_addr", um_tx_wr_addr, dst);
        chk("t3_stall_tag", um_tx_wr_tag, 8'd0);
        chk("t3_stall_data", um_tx_data, first_data);
      end
      step();
    end
    chk("t3_overflow", overflow, 1'b1);
    rdy_pct = 100;
    wait_done(d0);
    chk("t3_writes", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      chk("t3_addr", log_addr[i], dst + 58'(i));

    // Zero iterations: immediate completion, nothing written.
    log_addr.delete(); log_tag.delete();
    d0 = done_cnt;
    start_op(58'h55, 0);
    for (int i = 0; i < 3 && done_cnt == d0; i++) step();
    chk("t4_done_fast", done_cnt != d0, 1'b1);
    chk("t4_no_writes", log_addr.size(), 0);
    step();

    // Reset with writes outstanding, then a clean restart.
    rx_pct = 0;
    log_addr.delete(); log_tag.delete();
    start_op(58'h200, 1);
    for (int b = 0; b < 3; b++) begin
      update_valid = 1'b1; update_last = 1'b0; update = rand_wide();
      step();
    end
    update_valid = 1'b0;
    repeat (3) step();
    chk("t5_pre_writes", log_addr.size(), 3);
    chk("t5_pre_cnt", wr_debug_cnt, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t5_reset");
    um_rx_wr_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    rx_pct = 100;
    dst = 58'h0_00AB_CDEF_0000;
    log_addr.delete(); log_tag.delete();
    run_op(dst, 1, 4, 0);
    chk("t5_writes", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("t5_tag", log_tag[i], 8'(i));
      chk("t5_addr", log_addr[i], dst + 58'(i));
    end

    // Randomized operations against the model.
    for (int k = 0; k < 14; k++) begin
      rdy_pct  = $urandom_range(100, 30);
      rx_pct   = $urandom_range(100, 20);
      spur_pct = 5;
      run_op({$urandom, $urandom} & 58'h3FF_FFFF_FFFF_FFFF,
             (k % 7 == 6) ? 0 : $urandom_range(4, 1),
             $urandom_range(5, 1), $urandom_range(50, 0));
      repeat ($urandom_range(3, 0)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
